// File: rtl/rtc_apb_pkg.sv
// Shared types and RTC register map used by the APB requester and its bench.
package rtc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [7:0] RTC_ADDR_TIME  = 8'h00;
    localparam logic [7:0] RTC_ADDR_ALARM = 8'h04;
    localparam logic [7:0] RTC_ADDR_ADJ   = 8'h08;

    // Callers zero-extend their address, so wider buses never alias onto the map.
    function automatic logic is_rtc_addr(input logic [31:0] addr);
        return (addr == {24'h0, RTC_ADDR_TIME})  ||
               (addr == {24'h0, RTC_ADDR_ALARM}) ||
               (addr == {24'h0, RTC_ADDR_ADJ});
    endfunction

endpackage

// File: rtl/rtc_apb_master_if.sv
// Command, response and APB signals between the processor side, requester and RTC slave.
interface rtc_apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-cycle counter; expired_o flags the cycle in which the count reaches TIMEOUT.
module apb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looks at the next count so the FSM can leave ACCESS on the very edge the limit is hit.
    assign expired_o = en_i && (cnt_d == LIMIT);

endmodule

// File: rtl/rtc_apb_master.sv
// Single-beat APB requester for the RTC slave: address check, setup/access transfer, bounded wait.
module rtc_apb_master
    import rtc_apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    rtc_apb_master_if.master      bus
);
    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              expired;

    apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .pclk      (pclk),
        .preset    (preset),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q == ACCESS),
        .expired_o (expired)
    );

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (is_rtc_addr(32'(bus.cmd_addr))) begin
                            state_q  <= SETUP;
                            psel_q   <= 1'b1;
                            pwrite_q <= bus.cmd_write;
                            paddr_q  <= bus.cmd_addr;
                            pwdata_q <= bus.cmd_wdata;
                        end else begin
                            state_q     <= RESP;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so a reply on the last allowed cycle is not an error.
                    if (bus.pready) begin
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q   <= 1'b0;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (expired) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    // rsp_valid rises one cycle into RESP, after the response flops have settled.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_rtc_apb_master.sv
// Directed bench for rtc_apb_master with TIMEOUT=4 and hand-computed expectations.
module tb_rtc_apb_master;
    import rtc_apb_pkg::*;

    logic pclk;
    logic preset;
    int   n_run  = 0;
    int   n_fail = 0;
    int   acc_cnt;
    int   lat;

    rtc_apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    rtc_apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b1;
        bus.prdata    = '0;
        #3 preset = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        preset = 1'b1;
        step();
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Write 0x00 with single-cycle slave
        send(1'b1, RTC_ADDR_TIME, 32'h0012_3456);
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_setup_psel", 32'(bus.psel), 32'd1);
        chk("wr_setup_penable", 32'(bus.penable), 32'd0);
        chk("wr_setup_pwrite", 32'(bus.pwrite), 32'd1);
        chk("wr_setup_pwdata", bus.pwdata, 32'h0012_3456);
        chk("wr_setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("wr_access_penable", 32'(bus.penable), 32'd1);
        chk("wr_access_pwdata", bus.pwdata, 32'h0012_3456);
        step();
        chk("wr_resp_psel", 32'(bus.psel), 32'd0);
        chk("wr_early_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        ack_rsp();
        chk("wr_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wr_done_ready", 32'(bus.cmd_ready), 32'd1);

        // Read 0x00
        bus.prdata = 32'hDEAD_BEEF;
        send(1'b0, RTC_ADDR_TIME, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        chk("rd_setup_pwrite", 32'(bus.pwrite), 32'd0);
        chk("rd_setup_paddr", 32'(bus.paddr), 32'h00);
        step();
        chk("rd_access_penable", 32'(bus.penable), 32'd1);
        step();
        step();
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", 32'(bus.rsp_err), 32'd0);
        ack_rsp();

        // Unmapped write to 0x0C
        send(1'b1, 8'h0C, 32'h1111_1111);
        step();
        bus.cmd_valid = 1'b0;
        chk("unm_psel0", 32'(bus.psel), 32'd0);
        chk("unm_valid0", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("unm_psel1", 32'(bus.psel), 32'd0);
        chk("unm_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("unm_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("unm_rsp_rdata", bus.rsp_rdata, 32'h0);
        ack_rsp();
        chk("unm_done_valid", 32'(bus.rsp_valid), 32'd0);

        // Timeout: slave never ready
        bus.pready = 1'b0;
        bus.prdata = 32'h1234_5678;
        send(1'b0, RTC_ADDR_ALARM, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        acc_cnt = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.psel && bus.penable) acc_cnt++;
            if (bus.rsp_valid) break;
            step();
            lat++;
        end
        chk("to_access_cycles", 32'(acc_cnt), 32'd4);
        chk("to_latency", 32'(lat), 32'd6);
        chk("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("to_psel", 32'(bus.psel), 32'd0);
        ack_rsp();

        // pready arrives in the 4th ACCESS cycle
        bus.prdata = 32'hCAFE_F00D;
        send(1'b0, RTC_ADDR_ADJ, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        step();
        step();
        chk("late_access4_penable", 32'(bus.penable), 32'd1);
        bus.pready = 1'b1;
        step();
        chk("late_resp_psel", 32'(bus.psel), 32'd0);
        step();
        chk("late_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("late_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("late_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        ack_rsp();

        // Response back-pressure with a second command waiting
        bus.prdata = 32'h1111_2222;
        send(1'b0, RTC_ADDR_ALARM, 32'h0);
        step();
        send(1'b1, RTC_ADDR_ADJ, 32'hAAAA_5555);
        step();
        step();
        step();
        bus.prdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'h1111_2222);
            chk("bp_psel", 32'(bus.psel), 32'd0);
            step();
        end
        ack_rsp();
        chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp_idle_psel", 32'(bus.psel), 32'd0);
        step();
        bus.cmd_valid = 1'b0;
        chk("bp2_setup_psel", 32'(bus.psel), 32'd1);
        chk("bp2_setup_pwrite", 32'(bus.pwrite), 32'd1);
        chk("bp2_setup_paddr", 32'(bus.paddr), 32'h08);
        chk("bp2_setup_pwdata", bus.pwdata, 32'hAAAA_5555);
        step();
        step();
        step();
        chk("bp2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp2_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("bp2_rsp_rdata", bus.rsp_rdata, 32'h0);
        ack_rsp();

        // Asynchronous reset in the middle of ACCESS
        bus.pready = 1'b0;
        send(1'b1, RTC_ADDR_ADJ, 32'h55AA_55AA);
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("ar_access_penable", 32'(bus.penable), 32'd1);
        #2 preset = 1'b0;
        #1;
        chk("ar_psel", 32'(bus.psel), 32'd0);
        chk("ar_penable", 32'(bus.penable), 32'd0);
        chk("ar_pwrite", 32'(bus.pwrite), 32'd0);
        chk("ar_paddr", 32'(bus.paddr), 32'h0);
        chk("ar_pwdata", bus.pwdata, 32'h0);
        chk("ar_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        step();
        preset = 1'b1;
        bus.pready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ar_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("ar_ready_after", 32'(bus.cmd_ready), 32'd1);
        bus.prdata = 32'h0BAD_F00D;
        send(1'b0, RTC_ADDR_ALARM, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("ar_next_valid", 32'(bus.rsp_valid), 32'd1);
        chk("ar_next_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
        chk("ar_next_err", 32'(bus.rsp_err), 32'd0);
        ack_rsp();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
